// File: rtl/sort_sequencer.sv
// sort_sequencer: settle, measure, confirm and divert one object at a time via a servo PWM
module sort_sequencer #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int SETTLE_CYCLES = 10_000_000,
    parameter int MEAS_TIMEOUT  = 20_000_000,
    parameter int CONFIRM_N     = 3,
    parameter int SERVO_PERIOD  = 2_000_000,
    parameter int PULSE_HOME    = 150_000,
    parameter int PULSE_ACCEPT  = 200_000,
    parameter int PULSE_REJECT  = 100_000,
    parameter int HOLD_CYCLES   = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       object_present,
    input  logic [2:0] SW,
    input  logic       red_dominant,
    input  logic       green_dominant,
    input  logic       blue_dominant,
    input  logic       meas_done,
    output logic       meas_start,
    output logic       servo_pwm,
    output logic       busy,
    output logic       accept_pulse,
    output logic       reject_pulse,
    output logic       timeout_err,
    output logic [7:0] sorted_count
);
    function automatic int max_of(input int a, input int b);
        return a > b ? a : b;
    endfunction

    localparam int CW = $clog2(max_of(max_of(CLK_FREQ, HOLD_CYCLES),
                                      max_of(max_of(SETTLE_CYCLES, MEAS_TIMEOUT), SERVO_PERIOD))) + 1;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] SET_END  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_END  = CW'(MEAS_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] PER_END  = CW'(SERVO_PERIOD - 1);
    localparam logic [CW-1:0] P_HOME   = CW'(PULSE_HOME);
    localparam logic [CW-1:0] P_ACC    = CW'(PULSE_ACCEPT);
    localparam logic [CW-1:0] P_REJ    = CW'(PULSE_REJECT);
    localparam logic [3:0]    CONF     = 4'(CONFIRM_N);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DECIDE, S_HOLD, S_RETURN} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_target;
    logic [CW-1:0]   r_frame;
    logic [CW-1:0]   r_width;
    logic [3:0]      r_agree;
    logic            r_last;
    logic            r_meas_start;
    logic            r_accept;
    logic            r_reject;
    logic            r_timeout;
    logic            r_pwm;
    logic [7:0]      r_sorted;
    logic            w_match;
    logic [3:0]      w_agree_nxt;
    logic [CW-1:0]   w_frame_nxt;
    logic [CW-1:0]   w_width_nxt;

    assign w_match     = |(SW & {blue_dominant, green_dominant, red_dominant});
    assign w_agree_nxt = (r_agree == 4'd0 || w_match == r_last) ? r_agree + 4'd1 : 4'd1;
    assign w_frame_nxt = (r_frame == PER_END) ? '0 : r_frame + ONE;
    assign w_width_nxt = (w_frame_nxt == '0) ? r_target : r_width;

    assign meas_start   = r_meas_start;
    assign servo_pwm    = r_pwm;
    assign busy         = (r_state != S_IDLE);
    assign accept_pulse = r_accept;
    assign reject_pulse = r_reject;
    assign timeout_err  = r_timeout;
    assign sorted_count = r_sorted;

    // Sequencer: one shared counter serves settle, measurement timeout and hold phases
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_target     <= P_HOME;
            r_agree      <= '0;
            r_last       <= 1'b0;
            r_meas_start <= 1'b0;
            r_accept     <= 1'b0;
            r_reject     <= 1'b0;
            r_timeout    <= 1'b0;
            r_sorted     <= '0;
        end else begin
            r_meas_start <= 1'b0;
            r_accept     <= 1'b0;
            r_reject     <= 1'b0;
            case (r_state)
                S_IDLE: if (enable && object_present) begin
                    r_state <= S_SETTLE;
                    r_cnt   <= '0;
                end
                S_SETTLE: if (!object_present) r_state <= S_IDLE;
                else if (r_cnt == SET_END) begin
                    r_state      <= S_MEASURE;
                    r_meas_start <= 1'b1;
                    r_agree      <= '0;
                    r_cnt        <= '0;
                end else r_cnt <= r_cnt + ONE;
                S_MEASURE: if (meas_done) begin
                    r_agree <= w_agree_nxt;
                    r_last  <= w_match;
                    r_cnt   <= '0;
                    if (w_agree_nxt == CONF) begin
                        r_state  <= S_DECIDE;
                        r_accept <= w_match;
                        r_reject <= !w_match;
                        r_target <= w_match ? P_ACC : P_REJ;
                        if (w_match && r_sorted != 8'hFF) r_sorted <= r_sorted + 8'd1;
                    end else r_meas_start <= 1'b1;
                end else if (r_cnt == TMO_END) begin
                    r_timeout <= 1'b1;
                    r_state   <= S_RETURN;
                end else r_cnt <= r_cnt + ONE;
                S_DECIDE: begin
                    r_state <= S_HOLD;
                    r_cnt   <= '0;
                end
                S_HOLD: if (r_cnt == HOLD_END) r_state <= S_RETURN;
                else r_cnt <= r_cnt + ONE;
                S_RETURN: begin
                    r_target <= P_HOME;
                    if (!object_present) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Servo PWM: width only changes at a frame boundary so no frame is truncated or stretched
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame <= '0;
            r_width <= P_HOME;
            r_pwm   <= (PULSE_HOME > 0);
        end else begin
            r_frame <= w_frame_nxt;
            r_width <= w_width_nxt;
            r_pwm   <= (w_frame_nxt < w_width_nxt);
        end
    end
endmodule
